case_5_sdiv_6s_5s_6_seq: RTL and testbench
==========================================

CASE_5_SDIV_6S_5S_6_SEQ -- requirements
Module: case_5_sdiv_6s_5s_6_seq

Interface
REQ-001 SHALL have parameter ID, default 1, instance tag with no functional effect.
REQ-002 SHALL have parameter din0_WIDTH, default 6, signed dividend width.
REQ-003 SHALL have parameter din1_WIDTH, default 5, signed divisor width.
REQ-004 SHALL have parameter dout_WIDTH, default 6, signed quotient width, equal to din0_WIDTH.
REQ-005 SHALL have port clk, input, 1, sole clock, rising edge.
REQ-006 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-007 SHALL have port start, input, 1, request to accept din0/din1 this cycle.
REQ-008 SHALL have port ready, output, 1, high when start will be accepted.
REQ-009 SHALL have port din0, input, din0_WIDTH, signed dividend.
REQ-010 SHALL have port din1, input, din1_WIDTH, signed divisor.
REQ-011 SHALL have port done, output, 1, one-cycle pulse marking a new result.
REQ-012 SHALL have port dout, output, dout_WIDTH, signed quotient.
REQ-013 SHALL have port dbz, output, 1, divide-by-zero flag for the current result.
REQ-014 SHALL have port rem, output, din1_WIDTH, signed remainder, present only per REQ-027.

Function
REQ-015 SHALL implement a 3-state FSM: IDLE, BUSY and SIGN.
REQ-016 ready SHALL be 1 exactly in IDLE; start is ignored outside IDLE.
REQ-017 IDLE with start=1 at edge of cycle T SHALL register |din0|, |din1|, both sign bits and the zero-divisor condition, then enter BUSY.
REQ-018 BUSY SHALL perform one unsigned restoring shift-subtract step per cycle for din0_WIDTH cycles, counted by an iteration counter that resets to 0 on accept, then enter SIGN.
REQ-019 SIGN SHALL negate the quotient when operand signs differ and the remainder when the dividend is negative, register dout/rem/dbz, assert done for one cycle, and return to IDLE.
REQ-020 Latency SHALL be fixed: done high in cycle T+din0_WIDTH+2 (T+8 at defaults), with ready high in the same cycle.
REQ-021 start in the done cycle SHALL be accepted; back-to-back throughput is one result per din0_WIDTH+2 cycles.
REQ-022 dout, rem and dbz SHALL hold their values until the next done.
REQ-023 Quotient SHALL truncate toward zero and the remainder sign SHALL follow the dividend (C semantics); both are truncated to port width.
REQ-024 Overflow (most-negative dividend / -1) SHALL yield the truncated result, i.e. dout = most-negative value, with rem=0 and dbz=0.
REQ-025 A divisor of 0 SHALL still take the full latency and yield dout = all ones, rem = din0[din1_WIDTH-1:0], dbz=1.

Reset
REQ-026 reset SHALL asynchronously force IDLE, counter 0, dout 0, rem 0, dbz 0 and done 0; ready SHALL be 1 from the first edge after release; any operation in flight SHALL be discarded without a done.

Configuration
REQ-027 Macro CASE_5_SDIV_REM_EN SHALL be the only compile option: when defined, port rem exists and is driven per REQ-019/023..025; when undefined, port rem and all remainder sign-fix logic are absent, while the quotient, dbz and timing are unchanged.

Verification
REQ-028 A bench SHALL check reset release and start=1 with din0=-25, din1=4 at T -> done at T+8, dout=-6, rem=-1, dbz=0, ready low during T+1..T+7.
REQ-029 A bench SHALL check din0=31, din1=-5 -> dout=-6, rem=1; then din0=-32, din1=-1 -> dout=-32 (6'b100000), rem=0.
REQ-030 A bench SHALL check din0=13, din1=0 -> done at T+8, dout=6'b111111, rem=5'b01101, dbz=1; the next op 12/3 -> dout=4, dbz=0.
REQ-031 A bench SHALL check start held high continuously with alternating operands -> done every 8 cycles, each result correct, no missed or duplicated done.
REQ-032 A bench SHALL check reset asserted at T+4 of an operation -> no done, all outputs 0, and the next op 7/2 after release -> dout=3, rem=1.
REQ-033 A bench SHALL run an exhaustive sweep of all 64x32 operand pairs -> every result matches the C-semantics model, built both with and without CASE_5_SDIV_REM_EN.

Source files
------------

// File: rtl/case_5_sdiv_6s_5s_6_seq.sv
// case_5_sdiv_6s_5s_6_seq: sequential signed divider (restoring, one bit per cycle); CASE_5_SDIV_REM_EN adds the rem port.
module case_5_sdiv_6s_5s_6_seq #(
  parameter int ID = 1,
  parameter int din0_WIDTH = 6,
  parameter int din1_WIDTH = 5,
  parameter int dout_WIDTH = 6
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  output logic                  ready,
  input  logic [din0_WIDTH-1:0] din0,
  input  logic [din1_WIDTH-1:0] din1,
  output logic                  done,
  output logic [dout_WIDTH-1:0] dout,
  output logic                  dbz
`ifdef CASE_5_SDIV_REM_EN
  , output logic [din1_WIDTH-1:0] rem
`endif
);
  localparam int CW = $clog2(din0_WIDTH + 1) + 0 * ID;
  typedef enum logic [1:0] {IDLE, BUSY, SIGN} state_t;
  state_t state, state_nx;
  logic [CW-1:0] cnt;
  logic [din0_WIDTH-1:0] q;
  logic [din1_WIDTH-1:0] r, b, diff;
  logic [din1_WIDTH:0] r_sh;
  logic neg0, neg1, zero, ge;
  assign ready = state == IDLE;
  assign r_sh = {r, q[din0_WIDTH-1]};
  assign ge = r_sh >= {1'b0, b};
  assign diff = din1_WIDTH'(r_sh - {1'b0, b});
  always_comb begin
    state_nx = state;
    state_nx = state == IDLE ? (start ? BUSY : IDLE) :
               state == BUSY ? (cnt == CW'(din0_WIDTH - 1) ? SIGN : BUSY) : IDLE;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else state <= state_nx;
  // q holds |din0| and shifts quotient bits in from the right as dividend bits leave on the left
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
      q <= '0;
      r <= '0;
      b <= '0;
      neg0 <= 1'b0;
      neg1 <= 1'b0;
      zero <= 1'b0;
      dout <= '0;
      dbz <= 1'b0;
      done <= 1'b0;
`ifdef CASE_5_SDIV_REM_EN
      rem <= '0;
`endif
    end else begin
      done <= state == SIGN;
      if (state == IDLE && start) begin
        cnt <= '0;
        q <= din0[din0_WIDTH-1] ? -din0 : din0;
        r <= '0;
        b <= din1[din1_WIDTH-1] ? -din1 : din1;
        neg0 <= din0[din0_WIDTH-1];
        neg1 <= din1[din1_WIDTH-1];
        zero <= din1 == '0;
      end else if (state == BUSY) begin
        cnt <= cnt + 1'b1;
        q <= {q[din0_WIDTH-2:0], ge};
        r <= ge ? diff : r_sh[din1_WIDTH-1:0];
      end else if (state == SIGN) begin
        dout <= zero ? '1 : (neg0 ^ neg1) ? -q : q;
        dbz <= zero;
`ifdef CASE_5_SDIV_REM_EN
        // a zero divisor leaves the low dividend magnitude bits in r, so this restores din0's low bits
        rem <= neg0 ? -r : r;
`endif
      end
    end
  end
endmodule

// File: tb/tb_case_5_sdiv_6s_5s_6_seq.sv
// tb_case_5_sdiv_6s_5s_6_seq: directed, random and exhaustive checks of the sequential signed divider.
module tb_case_5_sdiv_6s_5s_6_seq;
  logic clk = 1'b0, reset = 1'b1, start = 1'b0;
  logic [5:0] din0 = '0;
  logic [4:0] din1 = '0;
  logic ready, done, dbz;
  logic [5:0] dout;
  logic [5:0] pq = '0;
  logic pz = 1'b0;
  int n_asrt = 0, n_fail = 0;
`ifdef CASE_5_SDIV_REM_EN
  logic [4:0] rem_o;
  logic [4:0] pr = '0;
`endif
  always #5 clk = ~clk;
  case_5_sdiv_6s_5s_6_seq #(.ID(1), .din0_WIDTH(6), .din1_WIDTH(5), .dout_WIDTH(6)) dut (
    .clk(clk), .reset(reset), .start(start), .ready(ready), .din0(din0), .din1(din1),
    .done(done), .dout(dout), .dbz(dbz)
`ifdef CASE_5_SDIV_REM_EN
    , .rem(rem_o)
`endif
  );
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  // C-semantics reference: truncating quotient, remainder takes dividend sign
  task automatic model(input int a, input int b, output logic [5:0] q, output logic [4:0] r, output logic z);
    logic signed [5:0] as;
    logic signed [4:0] bs;
    int ai, bi;
    as = 6'(a);
    bs = 5'(b);
    ai = as;
    bi = bs;
    z = bi == 0;
    q = z ? 6'h3f : 6'(ai / bi);
    r = z ? as[4:0] : 5'(ai % bi);
  endtask
  task automatic run_op(input int a, input int b, input bit keep);
    logic [5:0] eq;
    logic [4:0] er;
    logic ez;
    model(a, b, eq, er, ez);
    start = 1'b1;
    din0 = 6'(a);
    din1 = 5'(b);
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (k == 1 && !keep) start = 1'b0;
      if (k < 8) begin
        check("busy_done", done, 0);
        check("busy_ready", ready, 0);
        check("hold_dout", dout, pq);
        check("hold_dbz", dbz, pz);
`ifdef CASE_5_SDIV_REM_EN
        check("hold_rem", rem_o, pr);
`endif
      end
    end
    check("done", done, 1);
    check("done_ready", ready, 1);
    check("dout", dout, eq);
    check("dbz", dbz, ez);
`ifdef CASE_5_SDIV_REM_EN
    check("rem", rem_o, er);
    pr = er;
`endif
    pq = eq;
    pz = ez;
  endtask
  initial begin
    repeat (3) @(negedge clk);
    check("rst_done", done, 0);
    check("rst_dout", dout, 0);
    check("rst_dbz", dbz, 0);
    reset = 1'b0;
    @(negedge clk);
    check("rel_ready", ready, 1);
    check("rel_done", done, 0);
    run_op(-25, 4, 0);
    run_op(31, -5, 0);
    run_op(-32, -1, 0);
    run_op(13, 0, 0);
    run_op(12, 3, 0);
    for (int i = 0; i < 8; i++) run_op(i % 2 ? -25 : 31, i % 2 ? 4 : -5, 1);
    start = 1'b0;
    @(negedge clk);
    check("idle_done", done, 0);
    for (int i = 0; i < 40; i++) run_op(int'($urandom_range(63)), int'($urandom_range(31)), 0);
    for (int a = -32; a < 32; a++)
      for (int b = -16; b < 16; b++) run_op(a, b, 0);
    start = 1'b1;
    din0 = 6'd45;
    din1 = 5'd3;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      start = 1'b0;
    end
    reset = 1'b1;
    #1;
    check("mid_rst_done", done, 0);
    check("mid_rst_dout", dout, 0);
    check("mid_rst_dbz", dbz, 0);
    check("mid_rst_ready", ready, 1);
`ifdef CASE_5_SDIV_REM_EN
    check("mid_rst_rem", rem_o, 0);
    pr = '0;
`endif
    repeat (2) @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check("no_done_after_rst", done, 0);
      check("ready_after_rst", ready, 1);
    end
    pq = '0;
    pz = 1'b0;
    run_op(7, 2, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end
endmodule
